if_id_skid_stage: RTL and testbench

Parametrised, ready/valid successor to the fetch/decode pipeline register. It carries a PC and instruction word from fetch to decode with full backpressure, and uses an optional two-entry skid buffer so that `in_ready` is a registered signal. It supports synchronous flush with NOP insertion and exposes an occupancy count. It sits between the fetch unit (or I-cache response) and the decode stage; the hazard unit drives `flush` and decode drives `out_ready`.

---
 rtl/if_id_skid_stage.sv | 108 ++++++++++
 tb/tb_if_id_skid_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - fetch-to-decode ready/valid pipeline register with optional two-entry skid buffer
module if_id_skid_stage #(
    parameter int                  PC_W    = 32,
    parameter int                  INSTR_W = 32,
    parameter logic [INSTR_W-1:0]  NOP     = INSTR_W'(32'h00000013),
    parameter int                  SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         count
);

    // State encoding equals the occupancy so count comes straight from the state flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               acc;
    logic               pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;
    assign count     = state_q;

    // With the skid buffer, in_ready is just the complement of the "skid full" state bit.
    assign in_ready = (SKID != 0) ? (state_q != ST_TWO) : (out_ready || !out_valid);

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    main_pc_d    = in_pc;
                    main_instr_d = in_instr;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    main_pc_d    = in_pc;
                    main_instr_d = in_instr;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end else if (acc && (SKID != 0)) begin
                    skid_pc_d    = in_pc;
                    skid_instr_d = in_instr;
                    state_d      = ST_TWO;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Flush bubbles the output with NOP but tags it with the PC fetch is presenting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
        end else if (flush) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= in_pc;
            main_instr_q <= NOP;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - bench for if_id_skid_stage, SKID=0 and SKID=1 instances vs queue model
module tb_if_id_skid_stage;

    localparam logic [31:0] NOPV = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;

    logic        ir  [2];
    logic        ov  [2];
    logic [31:0] opc [2];
    logic [31:0] oin [2];
    logic [1:0]  cnt [2];

    int total = 0;
    int bad   = 0;

    logic [63:0] mq [2][$];
    logic [31:0] lpc  [2];
    logic [31:0] lins [2];
    bit          model_ok = 0;

    always #5 clk = ~clk;

    if_id_skid_stage #(.SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]),
        .out_instr(oin[0]), .count(cnt[0])
    );

    if_id_skid_stage #(.SKID(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]),
        .out_instr(oin[1]), .count(cnt[1])
    );

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s skid%0d got=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int k);
        if (k == 1) return mq[1].size() < 2;
        return out_ready || (mq[0].size() == 0);
    endfunction

    task automatic check_all();
        if (!model_ok) return;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] epc, ein;
            epc = (mq[k].size() > 0) ? mq[k][0][63:32] : lpc[k];
            ein = (mq[k].size() > 0) ? mq[k][0][31:0]  : lins[k];
            check("out_valid", k, {31'd0, ov[k]}, {31'd0, mq[k].size() > 0});
            check("in_ready",  k, {31'd0, ir[k]}, {31'd0, m_ready(k)});
            check("count",     k, {30'd0, cnt[k]}, mq[k].size());
            check("out_pc",    k, opc[k], epc);
            check("out_instr", k, oin[k], ein);
        end
    endtask

    task automatic model_edge();
        bit acc [2];
        bit pop [2];
        for (int k = 0; k < 2; k++) begin
            acc[k] = in_valid && m_ready(k);
            pop[k] = out_ready && (mq[k].size() > 0);
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                lpc[k]  = '0;
                lins[k] = NOPV;
            end else if (flush) begin
                mq[k].delete();
                lpc[k]  = in_pc;
                lins[k] = NOPV;
            end else begin
                if (mq[k].size() > 0) begin
                    lpc[k]  = mq[k][0][63:32];
                    lins[k] = mq[k][0][31:0];
                end
                if (pop[k]) void'(mq[k].pop_front());
                if (acc[k]) mq[k].push_back({in_pc, in_instr});
            end
        end
        if (rst) model_ok = 1;
    endtask

    // Drive inputs just after an edge, compare mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic fl, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = pc ^ 32'hA5A5_0000;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 1);
        check("rst_pc",    1, opc[1], 32'h0);
        check("rst_instr", 1, oin[1], NOPV);
        check("rst_ready", 1, {31'd0, ir[1]}, 32'd1);

        for (int i = 0; i < 8; i++) cycle(1, 32'(i * 4), 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);

        cycle(1, 32'h100, 0, 0, 0);
        cycle(1, 32'h104, 0, 0, 0);
        check("stall_cnt", 1, {30'd0, cnt[1]}, 32'd2);
        check("stall_rdy", 1, {31'd0, ir[1]}, 32'd0);
        cycle(1, 32'h108, 0, 0, 0);
        cycle(1, 32'h108, 1, 0, 0);
        check("drain_pc", 1, opc[1], 32'h104);
        cycle(1, 32'h108, 1, 0, 0);
        cycle(0, 32'h10C, 1, 0, 0);
        cycle(0, 32'h10C, 1, 0, 0);

        cycle(1, 32'h1F0, 0, 0, 0);
        cycle(1, 32'h1F4, 0, 0, 0);
        cycle(1, 32'h200, 0, 1, 0);
        check("flush_valid", 1, {31'd0, ov[1]}, 32'd0);
        check("flush_instr", 1, oin[1], NOPV);
        check("flush_pc",    1, opc[1], 32'h200);
        check("flush_cnt",   1, {30'd0, cnt[1]}, 32'd0);
        check("flush_rdy",   1, {31'd0, ir[1]}, 32'd1);
        cycle(0, 32'h204, 1, 0, 0);

        cycle(1, 32'h40, 0, 0, 0);
        cycle(1, 32'h44, 1, 0, 0);
        check("popacc_pc",  1, opc[1], 32'h44);
        check("popacc_cnt", 1, {30'd0, cnt[1]}, 32'd1);
        cycle(0, 32'h48, 1, 0, 0);

        cycle(1, 32'h300, 0, 0, 0);
        cycle(1, 32'h304, 0, 0, 0);
        cycle(0, 32'h308, 0, 0, 1);
        check("rst2_valid", 1, {31'd0, ov[1]}, 32'd0);
        check("rst2_pc",    1, opc[1], 32'h0);
        check("rst2_instr", 1, oin[1], NOPV);
        check("rst2_cnt",   1, {30'd0, cnt[1]}, 32'd0);

        cycle(1, 32'h400, 0, 0, 0);
        cycle(1, 32'h404, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 32'(32'h408 + i * 4), 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
